// File: rtl/relu_lane_sequencer.sv
// relu_lane_sequencer
//   Time-multiplexed ReLU stage for ap_fixed<21,7> activations. One shared
//   compare/mux lane replaces N_ELEM parallel lanes. Each ap_start launch
//   streams N_ELEM words from the upstream dense layer through a registered
//   valid/ack output stage. It pulses ap_done/ap_ready once the last result
//   has been consumed, and reports how many inputs had the sign bit set.
//
// Ports
//   ap_clk     : clock, rising edge
//   ap_rst     : synchronous active-high reset
//   ap_start   : launch request, sampled in IDLE only
//   ap_done    : one-cycle pulse when a launch completes
//   ap_idle    : high while IDLE
//   ap_ready   : one-cycle pulse, same cycle as ap_done
//   in_data    : signed input element
//   in_vld     : in_data valid
//   in_ack     : input accepted this cycle (combinational)
//   out_data   : registered ReLU result
//   out_vld    : out_data valid
//   out_ack    : downstream consumes out_data this cycle
//   neg_count  : count of negative inputs in the last launch
module relu_lane_sequencer #(
  parameter int W      = 21,
  parameter int N_ELEM = 3,
  parameter int CNT_W  = 2
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_vld,
  output logic             in_ack,
  output logic [W-1:0]     out_data,
  output logic             out_vld,
  input  logic             out_ack,
  output logic [CNT_W-1:0] neg_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_N_ELEM   = CNT_W'(N_ELEM);
  localparam logic [CNT_W-1:0] LP_LAST_IDX = CNT_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_neg;
  logic [W-1:0]     r_out_data;
  logic             r_out_vld;

  logic             w_in_ack;
  logic             w_xfer;
  logic             w_out_free;
  logic [W-1:0]     w_relu;

  // Positive values pass through with the sign bit cleared (it is already
  // zero); zero and every negative value, including the most negative, map
  // to zero. No rounding or saturation is needed at equal width.
  assign w_relu = ($signed(in_data) > $signed({W{1'b0}})) ?
                  {1'b0, in_data[W-2:0]} : {W{1'b0}};

  // Output slot is free when empty or being drained this cycle; this is what
  // lets one element per cycle flow with out_ack held high.
  assign w_out_free = !r_out_vld || out_ack;

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_in_ack    = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_in_ack = (r_cnt < LP_N_ELEM) && w_out_free;
        w_xfer   = in_vld && w_in_ack;
        if (w_xfer && (r_cnt == LP_LAST_IDX)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_out_free) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and the output register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_neg      <= '0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          // neg_count from the previous launch stays visible until here
          if (ap_start) begin
            r_cnt <= '0;
            r_neg <= '0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_out_data <= w_relu;
            r_out_vld  <= 1'b1;
            r_cnt      <= r_cnt + LP_ONE;
            if (in_data[W-1]) r_neg <= r_neg + LP_ONE;
          end else if (r_out_vld && out_ack) begin
            r_out_vld <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_out_free) r_out_vld <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign ap_idle   = (r_state == S_IDLE);
  assign ap_done   = (r_state == S_DONE);
  assign ap_ready  = (r_state == S_DONE);
  assign in_ack    = w_in_ack;
  assign out_data  = r_out_data;
  assign out_vld   = r_out_vld;
  assign neg_count = r_neg;

endmodule
